// File: rtl/spi_apb_pkg.sv
// ---------------------------------------------------------------------------
// spi_apb_pkg : APB master FSM states and SPI core register map   | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] DATA   = 3'b000;
  localparam logic [2:0] CTRL   = 3'b001;
  localparam logic [2:0] PRESC  = 3'b010;
  localparam logic [2:0] STATUS = 3'b011;

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// apb_timeout_cnt : counts consecutive ACCESS cycles, flags the LIMIT-th one | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at LAST so a completer that never answers cannot wrap the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge : single-outstanding command-to-APB bridge       | rev 1.0
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              w_timeout_hit;

  // With the feature disabled the counter is held cleared and folds away.
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .en_i      (TIMEOUT_EN && (state_q == ACCESS)),
    .expired_o (w_timeout_hit)
  );

  // Gated by PRESET so the handshake stays closed while reset is held.
  assign cmd_ready = (state_q == IDLE) && !PRESET;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = SETUP;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (w_timeout_hit) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge : directed self-checking bench for apb_master_bridge | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;
  import spi_apb_pkg::*;

  logic       PCLK;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic [2:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(
    .ADDR_W         (3),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; land just after the falling edge to sample and drive.
  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
    #1;
  endtask

  // Present a command for one acceptance edge; returns in the SETUP cycle.
  task automatic issue(input logic [2:0] a, input logic w, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 3'd0;
    cmd_write = 1'b0;
    cmd_wdata = 8'h00;
    PRDATA    = 8'h00;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;

    // Reset state
    tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    tick();
    PRESET = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Write DATA=A5 with zero-wait completer
    issue(DATA, 1'b1, 8'hA5);
    chk("wr_c1_psel", PSEL, 1);
    chk("wr_c1_penable", PENABLE, 0);
    chk("wr_c1_pwrite", PWRITE, 1);
    chk("wr_c1_pwdata", PWDATA, 8'hA5);
    chk("wr_c1_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_c2_penable", PENABLE, 1);
    chk("wr_c2_rsp_valid", rsp_valid, 0);
    tick();
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_err", rsp_err, 0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_psel", PSEL, 0);
    chk("wr_c3_cmd_ready", cmd_ready, 1);
    tick();
    chk("wr_c4_rsp_valid", rsp_valid, 0);

    // Read STATUS with two wait states
    PREADY = 1'b0;
    issue(STATUS, 1'b0, 8'hFF);
    chk("rd_c1_paddr", PADDR, 3'b011);
    chk("rd_c1_pwdata", PWDATA, 0);
    chk("rd_c1_pwrite", PWRITE, 0);
    tick();
    chk("rd_c2_penable", PENABLE, 1);
    tick();
    chk("rd_c3_penable", PENABLE, 1);
    chk("rd_c3_paddr", PADDR, 3'b011);
    chk("rd_c3_rsp_valid", rsp_valid, 0);
    tick();
    chk("rd_c4_paddr", PADDR, 3'b011);
    chk("rd_c4_rsp_valid", rsp_valid, 0);
    PREADY = 1'b1;
    PRDATA = 8'h5C;
    tick();
    chk("rd_c5_rsp_valid", rsp_valid, 1);
    chk("rd_c5_rsp_rdata", rsp_rdata, 8'h5C);
    chk("rd_c5_rsp_err", rsp_err, 0);
    PRDATA = 8'h00;
    tick();
    chk("rd_c6_rsp_valid", rsp_valid, 0);
    chk("rd_c6_rdata_hold", rsp_rdata, 8'h5C);

    // Completer never ready
    PREADY = 1'b0;
    issue(PRESC, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) tick();
    chk("to_c17_psel", PSEL, 1);
    chk("to_c17_rsp_valid", rsp_valid, 0);
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    chk("to_c18_rsp_valid", rsp_valid, 1);
    chk("to_c18_rsp_err", rsp_err, 1);
    chk("to_c18_rsp_timeout", rsp_timeout, 1);
    chk("to_c18_rsp_rdata", rsp_rdata, 0);
    chk("to_c18_psel", PSEL, 0);
    PREADY = 1'b1;
`else
    chk("to_c18_rsp_valid", rsp_valid, 0);
    chk("to_c18_psel", PSEL, 1);
    chk("to_c18_rsp_timeout", rsp_timeout, 0);
    PREADY = 1'b1;
    PRDATA = 8'h33;
    tick();
    chk("to_c19_rsp_valid", rsp_valid, 1);
    chk("to_c19_rsp_rdata", rsp_rdata, 8'h33);
    chk("to_c19_rsp_timeout", rsp_timeout, 0);
    PRDATA = 8'h00;
`endif
    tick();

    // Write CTRL=DB answered with slave error
    PSLVERR = 1'b1;
    issue(CTRL, 1'b1, 8'hDB);
    tick();
    tick();
    chk("err_c3_rsp_valid", rsp_valid, 1);
    chk("err_c3_rsp_err", rsp_err, 1);
    chk("err_c3_rsp_timeout", rsp_timeout, 0);
    PSLVERR = 1'b0;
    tick();
    chk("err_c4_err_hold", rsp_err, 1);

    // Reset in the middle of ACCESS
    PREADY = 1'b0;
    issue(STATUS, 1'b0, 8'h00);
    tick();
    chk("ab_c2_penable", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    chk("ab_psel_drop", PSEL, 0);
    chk("ab_penable_drop", PENABLE, 0);
    PREADY = 1'b1;
    tick();
    chk("ab_rsp_valid", rsp_valid, 0);
    chk("ab_rsp_err_clr", rsp_err, 0);
    PRESET = 1'b0;
    #1;
    chk("ab_cmd_ready", cmd_ready, 1);
    issue(PRESC, 1'b1, 8'h3C);
    chk("ab_next_pwdata", PWDATA, 8'h3C);
    tick();
    tick();
    chk("ab_next_rsp_valid", rsp_valid, 1);
    chk("ab_next_rsp_err", rsp_err, 0);
    tick();

    // Second command held while the first is busy
    PREADY    = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = DATA;
    cmd_write = 1'b1;
    cmd_wdata = 8'h11;
    tick();
    cmd_addr  = CTRL;
    cmd_write = 1'b0;
    cmd_wdata = 8'hEE;
    chk("b2b_c1_cmd_ready", cmd_ready, 0);
    chk("b2b_c1_pwdata", PWDATA, 8'h11);
    tick();
    chk("b2b_c2_cmd_ready", cmd_ready, 0);
    chk("b2b_c2_paddr", PADDR, 3'b000);
    PREADY = 1'b1;
    PRDATA = 8'h77;
    tick();
    chk("b2b_c3_rsp_valid", rsp_valid, 1);
    chk("b2b_c3_cmd_ready", cmd_ready, 1);
    chk("b2b_c3_rdata_wr", rsp_rdata, 0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_c4_psel", PSEL, 1);
    chk("b2b_c4_paddr", PADDR, 3'b001);
    chk("b2b_c4_pwrite", PWRITE, 0);
    chk("b2b_c4_pwdata", PWDATA, 0);
    tick();
    tick();
    chk("b2b_c6_rsp_valid", rsp_valid, 1);
    chk("b2b_c6_rsp_rdata", rsp_rdata, 8'h77);
    tick();
    chk("b2b_c7_idle", PSEL, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
